// File: rtl/glitch_sequencer.sv
// One-shot fault-injection sequencer: arm, wait for a qualified trigger edge,
// delay, then emit a burst of glitch pulses; pulses target reset on timeout.
module glitch_sequencer #(
   parameter int RST_CYCLES = 64,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arm,
   input  logic             abort,
   input  logic             trig_in,
   input  logic             trig_pol,
   input  logic [31:0]      delay,
   input  logic [31:0]      width,
   input  logic [31:0]      gap,
   input  logic [CNT_W-1:0] count,
   input  logic [31:0]      timeout,
   output logic             glitch_out,
   output logic             target_rst,
   output logic             busy,
   output logic             done,
   output logic             timed_out,
   output logic [CNT_W-1:0] pulse_idx,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_DELAY = 3'd2,
      S_PULSE = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5,
      S_TRST  = 3'd6
   } state_t;

   state_t           state, state_nx;
   logic [31:0]      cnt, cnt_nx;
   logic             idx_inc;
   logic             prev;
   logic             pol_q;
   logic [31:0]      delay_q, width_q, gap_q, timeout_q;
   logic [CNT_W-1:0] count_q;

   logic [31:0]      width_eff, gap_eff;
   logic [CNT_W-1:0] count_last;
   logic             edge_hit;
   logic             accept;

   assign width_eff  = (width_q == 32'd0) ? 32'd1 : width_q;
   assign gap_eff    = (gap_q == 32'd0) ? 32'd1 : gap_q;
   assign count_last = (count_q == '0) ? '0 : count_q - CNT_W'(1);
   assign edge_hit   = pol_q ? (trig_in & ~prev) : (~trig_in & prev);
   assign accept     = (state == S_IDLE) & arm & ~abort;
   assign dbg_state  = state;

   // Every counter compares against (value - 1) of a nonzero latched value,
   // so a full 32-bit delay never needs a 33rd bit.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_inc  = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nx = S_ARMED;
               cnt_nx   = 32'd0;
            end
         end
         S_ARMED: begin
            if (edge_hit) begin
               state_nx = (delay_q == 32'd0) ? S_PULSE : S_DELAY;
               cnt_nx   = 32'd0;
            end else if (timeout_q != 32'd0) begin
               if (cnt == timeout_q - 32'd1) begin
                  state_nx = S_TRST;
                  cnt_nx   = 32'd0;
               end else begin
                  cnt_nx = cnt + 32'd1;
               end
            end
         end
         S_DELAY: begin
            if (cnt == delay_q - 32'd1) begin
               state_nx = S_PULSE;
               cnt_nx   = 32'd0;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         S_PULSE: begin
            if (cnt == width_eff - 32'd1) begin
               state_nx = (pulse_idx == count_last) ? S_DONE : S_GAP;
               cnt_nx   = 32'd0;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         S_GAP: begin
            if (cnt == gap_eff - 32'd1) begin
               state_nx = S_PULSE;
               cnt_nx   = 32'd0;
               idx_inc  = 1'b1;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
            cnt_nx   = 32'd0;
         end
         S_TRST: begin
            if (cnt == 32'(RST_CYCLES - 1)) begin
               state_nx = S_IDLE;
               cnt_nx   = 32'd0;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = 32'd0;
         end
      endcase
      if (abort && state != S_IDLE) begin
         state_nx = S_IDLE;
         cnt_nx   = 32'd0;
         idx_inc  = 1'b0;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 32'd0;
         prev       <= 1'b0;
         pol_q      <= 1'b0;
         delay_q    <= 32'd0;
         width_q    <= 32'd0;
         gap_q      <= 32'd0;
         timeout_q  <= 32'd0;
         count_q    <= '0;
         glitch_out <= 1'b0;
         target_rst <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timed_out  <= 1'b0;
         pulse_idx  <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         prev       <= trig_in;
         glitch_out <= (state_nx == S_PULSE);
         target_rst <= (state_nx == S_TRST);
         busy       <= (state_nx != S_IDLE);
         done       <= (state_nx == S_DONE);
         if (accept) begin
            pol_q     <= trig_pol;
            delay_q   <= delay;
            width_q   <= width;
            gap_q     <= gap;
            count_q   <= count;
            timeout_q <= timeout;
            timed_out <= 1'b0;
            pulse_idx <= '0;
         end else begin
            if (idx_inc) pulse_idx <= pulse_idx + CNT_W'(1);
            if (state != S_TRST && state_nx == S_TRST) timed_out <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: a schedule-based model predicts every output
// cycle; directed shots add literal spot checks at hand-computed cycles.
module tb_glitch_sequencer;

   localparam int RST_CYCLES = 64;
   localparam int CNT_W      = 8;
   localparam int OW         = 5 + CNT_W;

   logic             clk = 1'b0;
   logic             rst, arm, abort, trig_in, trig_pol;
   logic [31:0]      delay, width, gap, timeout;
   logic [CNT_W-1:0] count;
   logic             glitch_out, target_rst, busy, done, timed_out;
   logic [CNT_W-1:0] pulse_idx;
   logic [2:0]       dbg_state;

   glitch_sequencer #(.RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_in(trig_in),
      .trig_pol(trig_pol), .delay(delay), .width(width), .gap(gap),
      .count(count), .timeout(timeout), .glitch_out(glitch_out),
      .target_rst(target_rst), .busy(busy), .done(done),
      .timed_out(timed_out), .pulse_idx(pulse_idx), .dbg_state(dbg_state)
   );

   // clock / cycle counter: cycle c is the window after the c-th posedge
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   longint cyc  = 0;

   // ---------------- behavioural model (shot schedule) ----------------
   typedef enum {M_IDLE, M_ARMED, M_BURST, M_TRST} mode_t;
   mode_t  mode = M_IDLE;
   logic   m_pol, m_prev = 1'b0;
   longint m_d, m_w, m_g, m_n, m_to, armed_n, base, done_cyc, trst_end, rel, per;
   logic   e_g, e_t, e_b, e_d, e_to;
   longint e_idx;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         mode  = M_IDLE;
         e_to  = 1'b0;
         e_idx = 0;
      end else begin
         case (mode)
            M_IDLE: if (arm && !abort) begin
               m_pol   = trig_pol;
               m_d     = longint'(delay);
               m_w     = (width == 0) ? 1 : longint'(width);
               m_g     = (gap == 0) ? 1 : longint'(gap);
               m_n     = (count == 0) ? 1 : longint'(count);
               m_to    = longint'(timeout);
               armed_n = 0;
               e_to    = 1'b0;
               e_idx   = 0;
               mode    = M_ARMED;
            end
            M_ARMED: begin
               if (abort) mode = M_IDLE;
               else if (m_pol ? (trig_in && !m_prev) : (!trig_in && m_prev)) begin
                  base     = cyc + m_d;
                  done_cyc = base + (m_n - 1) * (m_w + m_g) + m_w;
                  mode     = M_BURST;
               end else if (m_to != 0) begin
                  armed_n = armed_n + 1;
                  if (armed_n == m_to) begin
                     trst_end = cyc + RST_CYCLES;
                     e_to     = 1'b1;
                     mode     = M_TRST;
                  end
               end
            end
            M_BURST: if (abort || cyc > done_cyc) mode = M_IDLE;
            M_TRST:  if (abort || cyc >= trst_end) mode = M_IDLE;
            default: mode = M_IDLE;
         endcase
      end
      m_prev = trig_in;
      e_g = 1'b0; e_t = 1'b0; e_d = 1'b0;
      e_b = (mode != M_IDLE);
      if (mode == M_BURST) begin
         rel = cyc - base;
         per = m_w + m_g;
         if (rel >= 0) begin
            if (cyc == done_cyc) begin
               e_d   = 1'b1;
               e_idx = m_n - 1;
            end else begin
               e_g   = ((rel % per) < m_w);
               e_idx = rel / per;
            end
         end
      end
      if (mode == M_TRST) e_t = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   logic [OW-1:0] exp_v, act_v;
   assign exp_v = {e_g, e_t, e_b, e_d, e_to, CNT_W'(e_idx)};
   assign act_v = {glitch_out, target_rst, busy, done, timed_out, pulse_idx};

   always @(negedge clk) begin
      n_checks++;
      if (act_v !== exp_v)
         $display("FAIL model_cycle%0d {g,trst,busy,done,to,idx} act=%b exp=%b", cyc, act_v, exp_v);
      else
         n_pass++;
   end

   // ---------------- driver tasks ----------------
   task automatic at(input longint c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_at(input longint c, input string nm, input logic [31:0] act_sel, input logic [31:0] exp);
      // act_sel selects the output: 0 glitch,1 trst,2 busy,3 done,4 timed_out,5 idx,6 all
      logic [31:0] act;
      at(c);
      #3;
      case (act_sel)
         0: act = 32'(glitch_out);
         1: act = 32'(target_rst);
         2: act = 32'(busy);
         3: act = 32'(done);
         4: act = 32'(timed_out);
         5: act = 32'(pulse_idx);
         default: act = 32'(act_v);
      endcase
      n_checks++;
      if (act !== exp) $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic set_shot(input logic pol, input int d, input int w, input int g, input int n, input int to);
      trig_pol = pol; delay = d; width = w; gap = g; count = CNT_W'(n); timeout = to;
   endtask

   // arm issued in the current cycle; returns the first ARMED cycle
   task automatic do_arm(output longint a);
      arm = 1'b1;
      a = cyc + 1;
      at(a);
      arm = 1'b0;
   endtask

   localparam int SG = 0, ST = 1, SB = 2, SD = 3, SO = 4, SI = 5;

   longint a, k;

   initial begin
      rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
      set_shot(1'b1, 0, 1, 1, 1, 0);
      at(2);
      chk_at(2, "reset_outputs", 6, 0);
      rst = 1'b0;
      at(4);

      // shot 1: delay 10, width 3, gap 5, count 2, rising edge; arm mid-shot ignored
      set_shot(1'b1, 10, 3, 5, 2, 0);
      do_arm(a);
      k = a + 2;
      at(k); trig_in = 1'b1;
      at(k + 5); arm = 1'b1;
      at(k + 6); arm = 1'b0;
      chk_at(k + 10, "t1_g_before", SG, 0);
      chk_at(k + 11, "t1_g_first", SG, 1);
      chk_at(k + 13, "t1_g_third", SG, 1);
      chk_at(k + 14, "t1_g_gap", SG, 0);
      chk_at(k + 19, "t1_g_second", SG, 1);
      chk_at(k + 22, "t1_done", SD, 1);
      chk_at(k + 22, "t1_idx", SI, 1);
      chk_at(k + 23, "t1_busy_low", SB, 0);
      trig_in = 1'b0;
      at(k + 26);

      // shot 2a: all-zero params, falling edge, trigger high at arm
      trig_in = 1'b1;
      set_shot(1'b0, 0, 0, 0, 0, 0);
      do_arm(a);
      k = a + 3;
      at(k); trig_in = 1'b0;
      chk_at(k + 1, "t2_g_single", SG, 1);
      chk_at(k + 2, "t2_g_end", SG, 0);
      chk_at(k + 2, "t2_done", SD, 1);
      at(k + 5);

      // shot 2b: trigger already low at arm, then a non-qualifying rise
      do_arm(a);
      at(a + 3); trig_in = 1'b1;
      chk_at(a + 6, "t2b_no_pulse", SG, 0);
      chk_at(a + 6, "t2b_still_armed", SB, 1);
      abort = 1'b1;
      at(a + 7); abort = 1'b0;
      chk_at(a + 7, "t2b_abort_idle", SB, 0);
      trig_in = 1'b0;
      at(a + 10);

      // shot 3: timeout 20, no trigger
      set_shot(1'b1, 0, 1, 1, 1, 20);
      do_arm(a);
      chk_at(a + 19, "t3_trst_pre", ST, 0);
      chk_at(a + 20, "t3_trst_on", ST, 1);
      chk_at(a + 20, "t3_timed_out", SO, 1);
      chk_at(a + 83, "t3_trst_last", ST, 1);
      chk_at(a + 84, "t3_trst_off", ST, 0);
      chk_at(a + 84, "t3_to_sticky", SO, 1);
      at(a + 86);
      set_shot(1'b1, 0, 1, 1, 1, 0);
      do_arm(a);
      chk_at(a, "t3_to_cleared", SO, 0);
      at(a + 2); abort = 1'b1;
      at(a + 3); abort = 1'b0;
      at(a + 5);

      // shot 4: abort 40 cycles into a 100-cycle pulse, then a full shot
      set_shot(1'b1, 0, 100, 1, 1, 0);
      do_arm(a);
      k = a + 1;
      at(k); trig_in = 1'b1;
      at(k + 40); abort = 1'b1;
      chk_at(k + 40, "t4_g_pre_abort", SG, 1);
      at(k + 41); abort = 1'b0;
      chk_at(k + 41, "t4_g_aborted", SG, 0);
      chk_at(k + 41, "t4_busy_aborted", SB, 0);
      chk_at(k + 41, "t4_no_done", SD, 0);
      trig_in = 1'b0;
      at(k + 44);
      set_shot(1'b1, 10, 3, 5, 2, 0);
      do_arm(a);
      k = a + 1;
      at(k); trig_in = 1'b1;
      chk_at(k + 22, "t4_rerun_done", SD, 1);
      trig_in = 1'b0;
      at(k + 26);

      // shot 5: reset during gap, then arm together with abort in IDLE
      do_arm(a);
      k = a + 1;
      at(k); trig_in = 1'b1;
      at(k + 15); rst = 1'b1;
      at(k + 16); rst = 1'b0;
      chk_at(k + 16, "t5_rst_all_zero", 6, 0);
      trig_in = 1'b0;
      at(k + 18);
      arm = 1'b1; abort = 1'b1;
      at(k + 19); arm = 1'b0; abort = 1'b0;
      chk_at(k + 19, "t5_arm_abort_ignored", SB, 0);
      at(k + 21);

      // shot 6: edge on the final timeout cycle wins
      set_shot(1'b1, 2, 1, 1, 1, 5);
      do_arm(a);
      at(a + 4); trig_in = 1'b1;
      chk_at(a + 5, "t6_no_trst", ST, 0);
      chk_at(a + 7, "t6_pulse", SG, 1);
      chk_at(a + 8, "t6_done", SD, 1);
      chk_at(a + 8, "t6_no_timeout_flag", SO, 0);
      trig_in = 1'b0;
      at(a + 12);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Controller that sequences one fault-injection shot.
- Arms on request, waits for a qualified edge on the target trigger, waits a programmed delay, then emits a burst of N glitch pulses of programmed width and gap.
- If no trigger arrives within a timeout, pulses the target reset and reports the timeout.
- Sits between the host register block and the glitch driver. trig_in is already synchronized into clk by the caller.

Parameters:
- RST_CYCLES, 64, number of cycles target_rst is held high after a timeout.
- CNT_W, 8, width of count and pulse_idx.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle request to start a shot; sampled only in IDLE.
- abort  in  1  return to IDLE from any state.
- trig_in  in  1  synchronized target trigger level.
- trig_pol  in  1  1 = rising edge qualifies, 0 = falling edge qualifies.
- delay  in  32  cycles from edge to first pulse.
- width  in  32  glitch high time in cycles; 0 is treated as 1.
- gap  in  32  low time between pulses; 0 is treated as 1.
- count  in  CNT_W  pulses per shot; 0 is treated as 1.
- timeout  in  32  max cycles in ARMED; 0 = wait forever.
- glitch_out  out  1  registered glitch drive.
- target_rst  out  1  registered target reset request.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle strobe when a burst completes.
- timed_out  out  1  sticky flag; cleared on the next accepted arm.
- pulse_idx  out  CNT_W  index of the current or last pulse, 0-based.

Behaviour:
- Reset (rst=1 at posedge):
  - state IDLE; all counters 0.
  - glitch_out, target_rst, busy, done and timed_out are 0; pulse_idx is 0.
  - rst has priority over abort and arm.
- States: IDLE, ARMED, DELAY, PULSE, GAP, DONE, TRST.
- IDLE:
  - arm=1 -> ARMED next cycle.
  - On the same edge, latch trig_pol, delay, width, gap, count and timeout into shadow registers. Inputs changing mid-shot have no effect.
  - Load the edge-history register with the current trig_in, so a level already present is not an edge.
  - Clear timed_out and pulse_idx.
- ARMED:
  - Qualified edge is (trig_in & ~prev) for pol=1, (~trig_in & prev) for pol=0. prev updates every cycle.
  - Edge in cycle k: go to PULSE if delay==0, else DELAY.
  - No edge and timeout!=0: the timeout counter increments each ARMED cycle. After timeout ARMED cycles without an edge, go to TRST.
  - An edge on the final cycle of the timeout window wins over the timeout.
- DELAY: stay exactly delay cycles, then go to PULSE.
  - First glitch_out high cycle is k+1+delay.
- PULSE:
  - glitch_out=1 for exactly max(width,1) consecutive cycles.
  - If pulse_idx == max(count,1)-1, go to DONE; otherwise go to GAP.
- GAP:
  - glitch_out=0 for exactly max(gap,1) cycles.
  - pulse_idx increments on entry to the next PULSE, then go to PULSE.
- DONE: done=1 for one cycle, glitch_out=0, then IDLE. busy drops on the same cycle IDLE is entered.
- TRST: target_rst=1 for exactly RST_CYCLES cycles and timed_out set to 1, then IDLE.
- abort:
  - From any non-IDLE state, go to IDLE next cycle. glitch_out and target_rst are 0 from that cycle.
  - done is not pulsed and timed_out is unchanged.
  - If arm and abort are both high in IDLE, abort wins and the arm is ignored.
- arm while busy is ignored.
- glitch_out is a direct flop output, glitch-free, with no combinational path from inputs.
- Counters are 32-bit. delay=0xFFFFFFFF must work without wrap (compare against the latched value, no +1 overflow).

Test Plan:
- delay=10, width=3, gap=5, count=2, pol=1; arm, trig_in rising at cycle k -> glitch_out high k+11..k+13 and k+19..k+21; done at k+22; pulse_idx ends at 1.
- delay=0, width=0, count=0, pol=0, trig_in held high at arm then falls at k -> single 1-cycle pulse at k+1. No pulse if trig_in is already low at arm.
- timeout=20, no trigger -> target_rst high for 64 cycles starting after 20 ARMED cycles; timed_out=1; done never asserts. Next arm clears timed_out.
- abort mid-PULSE (width=100, abort at cycle 40 of the pulse) -> glitch_out low next cycle; busy low; no done. A following arm runs a full shot normally.
- rst asserted during GAP -> all outputs 0 next cycle. arm during busy, and arm with abort in IDLE -> both ignored.
- Trigger edge coincident with the last timeout cycle (timeout=5, edge on 5th ARMED cycle) -> burst proceeds, no target_rst.
